// File: rtl/prbs24_sync_checker.sv
// Self-synchronising checker for 24-bit Fibonacci PRBS streams: seeds from the
// stream, verifies predictions, then tracks errors, bit counts and lock status.
module prbs24_sync_checker #(
    parameter int LOCK_CNT    = 32,
    parameter int WIN_LEN     = 256,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic [1:0]       poly_sel,
    input  logic             resync,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             lock_lost,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      bit_cnt
);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [15:0] WIN_LAST  = 16'(WIN_LEN - 1);
    localparam logic [15:0] LOSS_LAST = 16'(LOSS_THRESH - 1);

    state_t      state;
    logic [23:0] h;
    logic [1:0]  sel_q;
    logic [4:0]  seed_cnt;
    logic [7:0]  match_cnt;
    logic [15:0] win_pos;
    logic [15:0] win_err;

    logic        pred;
    logic        mismatch;
    logic [23:0] h_din;
    logic        bit_inc;
    logic        err_inc;

    always_comb begin
        case (sel_q)
            2'd0:    pred = h[23] ^ h[22] ^ h[17] ^ h[0];
            2'd1:    pred = h[23] ^ h[22] ^ h[7]  ^ h[0];
            2'd2:    pred = h[23] ^ h[21] ^ h[20] ^ h[0];
            default: pred = h[23] ^ h[21] ^ h[11] ^ h[0];
        endcase
    end

    assign mismatch = din ^ pred;
    assign h_din    = {din, h[23:1]};
    // resync discards a coincident valid bit, so it never counts
    assign bit_inc  = (state == LOCKED) && din_valid && !resync;
    assign err_inc  = bit_inc && mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEED;
            h         <= '0;
            sel_q     <= poly_sel;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            err_flag  <= 1'b0;
            lock_lost <= 1'b0;

            if (clr_cnt) begin
                err_cnt <= ERR_W'(err_inc);
                bit_cnt <= 32'(bit_inc);
            end else begin
                if (err_inc && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
                if (bit_inc && !(&bit_cnt)) bit_cnt <= bit_cnt + 32'd1;
            end

            if (resync) begin
                state     <= SEED;
                seed_cnt  <= '0;
                match_cnt <= '0;
                sel_q     <= poly_sel;
                locked    <= 1'b0;
                lock_lost <= (state == LOCKED);
            end else if (din_valid) begin
                case (state)
                    SEED: begin
                        h <= h_din;
                        if (seed_cnt == 5'd23) begin
                            seed_cnt <= '0;
                            if (h_din != '0) begin
                                state     <= VERIFY;
                                match_cnt <= '0;
                            end
                        end else begin
                            seed_cnt <= seed_cnt + 5'd1;
                        end
                    end
                    VERIFY: begin
                        h <= h_din;
                        if (!mismatch) begin
                            if (match_cnt == LOCK_LAST) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                win_pos <= '0;
                                win_err <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            state    <= SEED;
                            seed_cnt <= '0;
                            sel_q    <= poly_sel;
                        end
                    end
                    LOCKED: begin
                        // feed back the prediction so a line error cannot corrupt h
                        h <= {pred, h[23:1]};
                        if (mismatch) err_flag <= 1'b1;
                        if (mismatch && win_err == LOSS_LAST) begin
                            state     <= SEED;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                            sel_q     <= poly_sel;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                        end else if (win_pos == WIN_LAST) begin
                            win_pos <= '0;
                            win_err <= '0;
                        end else begin
                            win_pos <= win_pos + 16'd1;
                            if (mismatch) win_err <= win_err + 16'd1;
                        end
                    end
                    default: state <= SEED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs24_sync_checker.sv
// Randomised bench for prbs24_sync_checker: behavioural model built from a bit
// history queue, per-cycle comparison, plus literal checkpoints from the test plan.
module tb_prbs24_sync_checker;

    localparam int LOCK_CNT    = 32;
    localparam int WIN_LEN     = 256;
    localparam int LOSS_THRESH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic [1:0]  poly_sel = 2'd0;
    logic        resync = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, lock_lost, err_flag;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;
    logic        locked_s, lock_lost_s, err_flag_s;
    logic [3:0]  err_cnt_s;
    logic [31:0] bit_cnt_s;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    prbs24_sync_checker dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .poly_sel(poly_sel),
        .resync(resync), .clr_cnt(clr_cnt), .locked(locked), .lock_lost(lock_lost),
        .err_flag(err_flag), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prbs24_sync_checker #(.ERR_W(4)) dut_s (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .poly_sel(poly_sel),
        .resync(resync), .clr_cnt(clr_cnt), .locked(locked_s), .lock_lost(lock_lost_s),
        .err_flag(err_flag_s), .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s)
    );

    // ---------------- behavioural model ----------------
    bit     hq[$];               // hq[0] oldest received bit, hq[23] newest
    int     m_mode;              // 0 seeding, 1 verifying, 2 locked
    int     m_sel, m_seedn, m_match, m_wpos, m_werr;
    longint m_ecnt, m_ecnt4, m_bcnt;
    logic   n_locked, n_lost, n_flag;
    logic   e_locked = 1'b0, e_lost = 1'b0, e_flag = 1'b0;
    longint e_ecnt = 0, e_ecnt4 = 0, e_bcnt = 0;

    function automatic bit mpred();
        int a, b;
        case (m_sel)
            0:       begin a = 22; b = 17; end
            1:       begin a = 22; b = 7;  end
            2:       begin a = 21; b = 20; end
            default: begin a = 21; b = 11; end
        endcase
        return hq[23] ^ hq[a] ^ hq[b] ^ hq[0];
    endfunction

    function automatic bit hzero();
        foreach (hq[i]) if (hq[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic shift_in(input bit b);
        hq.push_back(b);
        void'(hq.pop_front());
    endtask

    task automatic model_step();
        bit p, ie, ib;
        n_flag = 1'b0; n_lost = 1'b0; ie = 1'b0; ib = 1'b0;
        if (rst) begin
            hq.delete();
            repeat (24) hq.push_back(1'b0);
            m_mode = 0; m_sel = int'(poly_sel); m_seedn = 0; m_match = 0;
            m_wpos = 0; m_werr = 0; m_ecnt = 0; m_ecnt4 = 0; m_bcnt = 0;
        end else begin
            if (resync) begin
                if (m_mode == 2) n_lost = 1'b1;
                m_mode = 0; m_seedn = 0; m_match = 0; m_sel = int'(poly_sel);
            end else if (din_valid) begin
                p = mpred();
                if (m_mode == 0) begin
                    shift_in(din);
                    m_seedn++;
                    if (m_seedn == 24) begin
                        m_seedn = 0;
                        if (!hzero()) begin m_mode = 1; m_match = 0; end
                    end
                end else if (m_mode == 1) begin
                    shift_in(din);
                    if (din == p) begin
                        m_match++;
                        if (m_match == LOCK_CNT) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
                    end else begin
                        m_mode = 0; m_seedn = 0; m_sel = int'(poly_sel);
                    end
                end else begin
                    shift_in(p);
                    ib = 1'b1;
                    if (din != p) begin ie = 1'b1; n_flag = 1'b1; m_werr++; end
                    if (m_werr == LOSS_THRESH) begin
                        m_mode = 0; m_seedn = 0; m_match = 0; m_sel = int'(poly_sel);
                        n_lost = 1'b1;
                    end else if (m_wpos == WIN_LEN - 1) begin
                        m_wpos = 0; m_werr = 0;
                    end else begin
                        m_wpos++;
                    end
                end
            end
            if (clr_cnt) begin
                m_ecnt = ie; m_ecnt4 = ie; m_bcnt = ib;
            end else begin
                if (ie && m_ecnt < 65535) m_ecnt++;
                if (ie && m_ecnt4 < 15) m_ecnt4++;
                if (ib && m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
            end
        end
        n_locked = (m_mode == 2);
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("locked",      64'(locked),      64'(e_locked));
            cmp("lock_lost",   64'(lock_lost),   64'(e_lost));
            cmp("err_flag",    64'(err_flag),    64'(e_flag));
            cmp("err_cnt",     64'(err_cnt),     64'(e_ecnt));
            cmp("bit_cnt",     64'(bit_cnt),     64'(e_bcnt));
            cmp("s_locked",    64'(locked_s),    64'(e_locked));
            cmp("s_lock_lost", 64'(lock_lost_s), 64'(e_lost));
            cmp("s_err_flag",  64'(err_flag_s),  64'(e_flag));
            cmp("s_err_cnt",   64'(err_cnt_s),   64'(e_ecnt4));
            cmp("s_bit_cnt",   64'(bit_cnt_s),   64'(e_bcnt));
        end
    end

    // ---------------- stimulus ----------------
    logic [23:0] g;
    int          gp;

    function automatic logic gfb(input logic [23:0] s, input int p);
        case (p)
            0:       return s[23] ^ s[22] ^ s[17] ^ s[0];
            1:       return s[23] ^ s[22] ^ s[7]  ^ s[0];
            2:       return s[23] ^ s[21] ^ s[20] ^ s[0];
            default: return s[23] ^ s[21] ^ s[11] ^ s[0];
        endcase
    endfunction

    task automatic gen(output logic b);
        b = g[0];
        g = {gfb(g, gp), g[23:1]};
    endtask

    task automatic step(input logic d, input logic v, input logic rs, input logic cc);
        din = d; din_valid = v; resync = rs; clr_cnt = cc;
        model_step();
        @(posedge clk);
        e_locked = n_locked; e_lost = n_lost; e_flag = n_flag;
        e_ecnt = m_ecnt; e_ecnt4 = m_ecnt4; e_bcnt = m_bcnt;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic send_clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic           b;
        logic [255:0]   emask;
        int             cnt, pos, vcnt;
        logic           v, rs, cc, inj;

        do_reset();
        check_en = 1'b1;
        cmp("rst_locked",  64'(locked),    64'd0);
        cmp("rst_err_cnt", 64'(err_cnt),   64'd0);
        cmp("rst_bit_cnt", 64'(bit_cnt),   64'd0);
        cmp("rst_lost",    64'(lock_lost), 64'd0);

        // clean lock, poly 0, seed 1
        gp = 0; g = 24'h000001;
        send_clean(55);
        cmp("lock_55", 64'(locked), 64'd0);
        send_clean(1);
        cmp("lock_56", 64'(locked), 64'd1);
        send_clean(1000);
        cmp("clean_err_cnt", 64'(err_cnt), 64'd0);
        cmp("clean_bit_cnt", 64'(bit_cnt), 64'd1000);

        // single error
        send_clean(99);
        gen(b); step(~b, 1'b1, 1'b0, 1'b0);
        cmp("single_flag",   64'(err_flag), 64'd1);
        cmp("single_cnt",    64'(err_cnt),  64'd1);
        cmp("single_locked", 64'(locked),   64'd1);
        send_clean(1);
        cmp("single_next",   64'(err_flag), 64'd0);

        // move into a fresh window, then 8 errors in 15 bits
        send_clean(200);
        for (int i = 0; i < 15; i++) begin
            gen(b); step(b ^ (i % 2 == 0), 1'b1, 1'b0, 1'b0);
        end
        cmp("loss_pulse",  64'(lock_lost), 64'd1);
        cmp("loss_locked", 64'(locked),    64'd0);
        cmp("loss_cnt",    64'(err_cnt),   64'd9);
        send_clean(55);
        cmp("relock_55", 64'(locked), 64'd0);
        send_clean(1);
        cmp("relock_56", 64'(locked), 64'd1);

        // 7 random errors per window for 3 windows: lock holds, 4-bit count saturates
        for (int w = 0; w < 3; w++) begin
            emask = '0; cnt = 0;
            while (cnt < 7) begin
                pos = $urandom_range(255);
                if (!emask[pos]) begin emask[pos] = 1'b1; cnt++; end
            end
            for (int i = 0; i < 256; i++) begin
                gen(b); step(b ^ emask[i], 1'b1, 1'b0, 1'b0);
            end
        end
        cmp("win7_locked", 64'(locked),    64'd1);
        cmp("win7_cnt",    64'(err_cnt),   64'd30);
        cmp("sat_cnt4",    64'(err_cnt_s), 64'd15);

        // resync out of lock, then constant zeros
        step(1'b0, 1'b0, 1'b1, 1'b0);
        cmp("resync_lost",   64'(lock_lost), 64'd1);
        cmp("resync_locked", 64'(locked),    64'd0);
        for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        cmp("zeros_locked", 64'(locked), 64'd0);

        // poly-3 stream against poly 0
        gp = 3; g = 24'h5A5A5A;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_clean(600);
        cmp("wrongpoly_locked", 64'(locked), 64'd0);

        // select poly 3 via resync; coincident valid bit is discarded
        poly_sel = 2'd3;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        send_clean(55);
        cmp("poly3_55", 64'(locked), 64'd0);
        send_clean(1);
        cmp("poly3_56", 64'(locked), 64'd1);

        // valid gaps: same lock point counted in valid bits
        poly_sel = 2'd0;
        do_reset();
        gp = 0; g = 24'h000001; vcnt = 0;
        while (vcnt < 56) begin
            if ($urandom_range(1) == 1) begin
                gen(b); step(b, 1'b1, 1'b0, 1'b0);
                vcnt++;
                if (vcnt == 55) cmp("gap_55", 64'(locked), 64'd0);
            end else begin
                step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
            end
        end
        cmp("gap_56",     64'(locked),  64'd1);
        cmp("gap_bitcnt", 64'(bit_cnt), 64'd0);

        // random traffic: gaps, errors, clears, resyncs
        for (int i = 0; i < 1500; i++) begin
            v   = 1'($urandom_range(1));
            inj = ($urandom_range(63) == 0);
            cc  = ($urandom_range(99) == 0);
            rs  = ($urandom_range(299) == 0);
            if (v && !rs) begin
                gen(b); step(b ^ inj, 1'b1, 1'b0, cc);
            end else begin
                step(1'($urandom_range(1)), v, rs, cc);
            end
        end

        // reset in the middle of lock
        send_clean(100);
        cmp("pre_rst_locked", 64'(locked), 64'd1);
        do_reset();
        cmp("midrst_locked", 64'(locked),    64'd0);
        cmp("midrst_err",    64'(err_cnt),   64'd0);
        cmp("midrst_bits",   64'(bit_cnt),   64'd0);
        cmp("midrst_lost",   64'(lock_lost), 64'd0);

        // clr_cnt coincident with an error
        send_clean(56);
        cmp("clr_locked", 64'(locked), 64'd1);
        send_clean(10);
        gen(b); step(~b, 1'b1, 1'b0, 1'b1);
        cmp("clr_err_cnt", 64'(err_cnt),  64'd1);
        cmp("clr_bit_cnt", 64'(bit_cnt),  64'd1);
        cmp("clr_flag",    64'(err_flag), 64'd1);
        send_clean(5);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
